// File: rtl/sync_fifo_mc_if.sv
// Handshake and status bundle for the multi-channel FIFO.
// The FIFO connects to the slave modport; the producer/consumer side uses master.
interface sync_fifo_mc_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 6,
  parameter int NUM_CH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]       flush_en;
  logic [NUM_CH-1:0]       enq_valid;
  logic [NUM_CH-1:0]       enq_ready;
  logic [NUM_CH*WIDTH-1:0] enq_data;
  logic [NUM_CH-1:0]       deq_valid;
  logic [NUM_CH-1:0]       deq_ready;
  logic [NUM_CH*WIDTH-1:0] deq_data;
  logic [NUM_CH*CW-1:0]    count;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH-1:0]       almost_empty;

  modport master (
    output flush_en, enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count, almost_full, almost_empty
  );

  modport slave (
    input  flush_en, enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count, almost_full, almost_empty
  );
endinterface

// File: rtl/sync_fifo_mc.sv
// NUM_CH independent show-ahead FIFOs of DEPTH entries on one clock, each with
// its own flush, occupancy count and almost-full/almost-empty flags.
module sync_fifo_mc #(
  parameter int WIDTH                  = 32,
  parameter int DEPTH                  = 6,
  parameter int NUM_CH                 = 4,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_mc_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  logic [NUM_CH-1:0]       enq_ready_w;
  logic [NUM_CH-1:0]       deq_valid_w;
  logic [NUM_CH-1:0]       almost_full_w;
  logic [NUM_CH-1:0]       almost_empty_w;
  logic [NUM_CH*WIDTH-1:0] deq_data_w;
  logic [NUM_CH*CW-1:0]    count_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic             do_enq;
    logic             do_deq;

    // Ready/valid come only from the registered count, never from the partner's request.
    assign enq_ready_w[c]    = (cnt != FULL_COUNT);
    assign deq_valid_w[c]    = (cnt != '0);
    assign almost_full_w[c]  = (int'(cnt) >= ALMOST_FULL_THRESHOLD);
    assign almost_empty_w[c] = (int'(cnt) <= ALMOST_EMPTY_THRESHOLD);
    assign count_w[c*CW +: CW]         = cnt;
    assign deq_data_w[c*WIDTH +: WIDTH] = mem[head];

    assign do_enq = bus.enq_valid[c] && enq_ready_w[c];
    assign do_deq = bus.deq_ready[c] && deq_valid_w[c];

    always_ff @(posedge clk) begin
      if (rst_n && !bus.flush_en[c] && do_enq)
        mem[tail] <= bus.enq_data[c*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
      if (!rst_n || bus.flush_en[c]) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (do_enq)
          tail <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
        if (do_deq)
          head <= (head == LAST_PTR) ? '0 : head + PW'(1);
        if (do_enq && !do_deq)
          cnt <= cnt + CW'(1);
        else if (!do_enq && do_deq)
          cnt <= cnt - CW'(1);
      end
    end
  end

  assign bus.enq_ready    = enq_ready_w;
  assign bus.deq_valid    = deq_valid_w;
  assign bus.almost_full  = almost_full_w;
  assign bus.almost_empty = almost_empty_w;
  assign bus.deq_data     = deq_data_w;
  assign bus.count        = count_w;
endmodule
